// File: rtl/comm_pkg.sv
// Shared types for the comm unit: the packet layout and the assembler states.
package comm_pkg;

  localparam int PKT_W   = 136;
  localparam int SIZE_W  = 8;
  localparam int FIELD_W = 64;

  // One sparse-vector packet, laid out the same way as the comm unit's tx_data.
  typedef struct packed {
    logic [SIZE_W-1:0]  size;
    logic [FIELD_W-1:0] values;
    logic [FIELD_W-1:0] indices;
  } vec_pkt_t;

  typedef enum logic [1:0] {
    IDLE,
    VALS,
    IDXS,
    OUT
  } asm_state_t;

  // A non-zero size is usable only if it is even and fits the field.
  function automatic logic size_is_legal(input logic [SIZE_W-1:0] size,
                                         input logic [SIZE_W-1:0] max_size);
    return !size[0] && (size <= max_size);
  endfunction

endpackage

// File: rtl/byte_field_writer.sv
// Field register that fills MSB-first, one byte per write, with a clear.
module byte_field_writer
  import comm_pkg::*;
#(
  parameter int WIDTH = FIELD_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic [$clog2(WIDTH/8)-1:0] idx,
  input  logic [7:0]                 data,
  output logic [WIDTH-1:0]           field
);

  localparam int NUM_BYTES = WIDTH / 8;
  localparam int IDX_W     = $clog2(NUM_BYTES);

  // Byte idx 0 is the most significant byte; clear wins over a write.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      field <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (idx == IDX_W'(i)) begin
          field[WIDTH-1-8*i -: 8] <= data;
        end
      end
    end
  end

endmodule

// File: rtl/vec_packet_assembler.sv
// Assembles a sparse-vector packet (size, values, indices) from the UART byte
// stream and offers it to the row/column buffer over valid/ready.
module vec_packet_assembler
  import comm_pkg::*;
#(
  parameter int MAX_BYTES      = 8,
  parameter int FIELD_W        = 64,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  byte_in,
  input  logic                        byte_valid,
  output logic [SIZE_W+2*FIELD_W-1:0] pkt_data,
  output logic                        pkt_valid,
  input  logic                        pkt_ready,
  output logic                        busy,
  output logic                        err_size,
  output logic                        err_timeout,
  output logic                        err_overrun
);

  localparam int                IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SIZE_W-1:0] MAX_SIZE   = SIZE_W'(MAX_BYTES);
  localparam int                IDX_W      = $clog2(FIELD_W / 8);

  asm_state_t        state;
  logic [SIZE_W-1:0] size_r;
  logic [3:0]        cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [FIELD_W-1:0] values;
  logic [FIELD_W-1:0] indices;

  logic clear_fields;
  logic val_wr;
  logic idx_wr;
  logic last_byte;
  logic timed_out;
  logic size_ok;

  assign last_byte = ({{(SIZE_W-4){1'b0}}, cnt} == (size_r - SIZE_W'(1)));
  assign size_ok   = size_is_legal(byte_in, MAX_SIZE);
  assign timed_out = ((state == VALS) || (state == IDXS)) && !byte_valid &&
                     (idle_cnt == IDLE_LIMIT);
  assign busy      = (state != IDLE);
  assign pkt_data  = {size_r, values, indices};

  // Field-writer controls: clear on a new accepted size or an aborted packet.
  always_comb begin
    clear_fields = 1'b0;
    val_wr       = 1'b0;
    idx_wr       = 1'b0;
    if ((state == IDLE) && byte_valid && ((byte_in == 8'd0) || size_ok)) begin
      clear_fields = 1'b1;
    end
    if (timed_out) begin
      clear_fields = 1'b1;
    end
    if ((state == VALS) && byte_valid) begin
      val_wr = 1'b1;
    end
    if ((state == IDXS) && byte_valid) begin
      idx_wr = 1'b1;
    end
  end

  byte_field_writer #(.WIDTH(FIELD_W)) u_values (
    .clk   (clk),
    .reset (reset),
    .clear (clear_fields),
    .wr_en (val_wr),
    .idx   (cnt[IDX_W-1:0]),
    .data  (byte_in),
    .field (values)
  );

  byte_field_writer #(.WIDTH(FIELD_W)) u_indices (
    .clk   (clk),
    .reset (reset),
    .clear (clear_fields),
    .wr_en (idx_wr),
    .idx   (cnt[IDX_W-1:0]),
    .data  (byte_in),
    .field (indices)
  );

  // Packet FSM with byte counter, inter-byte timeout and registered flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      size_r      <= '0;
      cnt         <= '0;
      idle_cnt    <= '0;
      pkt_valid   <= 1'b0;
      err_size    <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_size    <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      case (state)
        IDLE: begin
          idle_cnt <= '0;
          cnt      <= '0;
          if (byte_valid) begin
            if (byte_in == 8'd0) begin
              size_r    <= '0;
              pkt_valid <= 1'b1;
              state     <= OUT;
            end else if (size_ok) begin
              size_r <= byte_in;
              state  <= VALS;
            end else begin
              err_size <= 1'b1;
            end
          end
        end
        VALS, IDXS: begin
          if (byte_valid) begin
            idle_cnt <= '0;
            if (last_byte) begin
              cnt <= '0;
              if (state == VALS) begin
                state <= IDXS;
              end else begin
                pkt_valid <= 1'b1;
                state     <= OUT;
              end
            end else begin
              cnt <= cnt + 4'd1;
            end
          end else if (timed_out) begin
            state       <= IDLE;
            size_r      <= '0;
            cnt         <= '0;
            idle_cnt    <= '0;
            err_timeout <= 1'b1;
          end else if (idle_cnt != '1) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end
        OUT: begin
          if (byte_valid) begin
            err_overrun <= 1'b1;
          end
          if (pkt_ready) begin
            pkt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/vec_packet_assembler.md
Name: vec_packet_assembler

Overview:
- Sits directly downstream of the comm unit's UART receiver, in load mode (op=0).
- Consumes the received byte stream and assembles one sparse-vector packet. A packet is a size byte, then `size` value bytes, then `size` index bytes.
- Presents the packet as a 136-bit word, {size, values[63:0], indices[63:0]}. This is the same layout the comm unit uses for tx_data.
- Hands the word to the row/column buffer of the multiplier over a valid/ready handshake.

Parameters:
- MAX_BYTES, 8, maximum legal size value (4 elements x 2 bytes).
- FIELD_W, 64, width of the values field and of the indices field.
- TIMEOUT_CYCLES, 50000, idle clk cycles allowed between bytes mid-packet (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- byte_in  in  8  received byte from the UART receiver.
- byte_valid  in  1  one-cycle strobe: byte_in is valid.
- pkt_data  out  136  {size[7:0], values[63:0], indices[63:0]}.
- pkt_valid  out  1  pkt_data is valid; held until accepted.
- pkt_ready  in  1  consumer accepts when pkt_valid && pkt_ready.
- busy  out  1  high in any state other than IDLE.
- err_size  out  1  one-cycle pulse: size byte rejected.
- err_timeout  out  1  one-cycle pulse: packet aborted by inter-byte timeout.
- err_overrun  out  1  one-cycle pulse: byte dropped while in OUT.

Behaviour:
- Reset values: all outputs 0; pkt_data 0; state IDLE; all counters 0. Reset mid-packet discards partial data immediately.
- States: IDLE, VALS, IDXS, OUT.
- IDLE, on byte_valid:
  - size 0: latch size, clear both fields, go to OUT (empty vector).
  - size odd or size > MAX_BYTES: pulse err_size the next cycle and stay in IDLE.
  - otherwise: latch size, clear the values and indices fields, clear byte counter cnt, go to VALS.
- VALS, on byte_valid:
  - Write byte_in to values[63-8*cnt -: 8]. The first byte lands in the MSB byte, matching the host's MSB-first shifting; unused low bytes stay 0.
  - cnt++. When cnt reaches size-1 on this byte, reset cnt to 0 and go to IDXS.
- IDXS: same as VALS, writing the indices field. On the last byte go to OUT.
- OUT:
  - pkt_valid = 1, registered. It rises the cycle after the last byte is accepted, so latency is 1 clk.
  - pkt_data is stable while pkt_valid && !pkt_ready.
  - On pkt_ready, go to IDLE; pkt_valid = 0 the next cycle.
  - byte_valid in OUT: the byte is dropped and err_overrun pulses.
  - If pkt_ready and byte_valid arrive in the same cycle in OUT, the byte is still dropped. The block never accepts a byte in OUT.
- Timeout:
  - An idle counter runs only in VALS and IDXS, clears on every byte_valid, and saturates.
  - When it reaches TIMEOUT_CYCLES-1 with no byte, go to IDLE and pulse err_timeout; partial data is discarded.
  - The counter never runs in IDLE or OUT. OUT may wait indefinitely for pkt_ready.
- Widths: cnt is 4 bits; size is compared unsigned.
- Error pulses are mutually exclusive by construction.
- busy = (state != IDLE).

Decomposition:
- Shared package comm_pkg holds:
  - PKT_W = 136, SIZE_W = 8, FIELD_W = 64;
  - a packed struct vec_pkt_t {size, values, indices};
  - the state enum asm_state_t.
- One sub-module: byte_field_writer. It does an MSB-first byte insert into a 64-bit register, with clear and write-enable. It is instantiated twice, once for values and once for indices.
- Timeout counter and FSM stay in the top module.

Test Plan:
- Nominal packet: feed bytes 04 74 FB 7B FE 00 00 00 03 with pkt_ready=1 → one pkt_valid pulse, pkt_data = {8'h04, 64'h74FB7BFE00000000, 64'h0000000300000000}, 1 clk after the last byte.
- Full packet: size 08, values 74 FB 7B FE 97 8F 83 D7, indices 00 00 00 01 00 02 00 03 → pkt_data = {8'h08, 64'h74FB7BFE978F83D7, 64'h0000000100020003}.
- Backpressure plus overrun: nominal packet with pkt_ready=0 for 20 cycles and one extra byte injected during the stall → pkt_data held constant, err_overrun pulses once. Releasing ready completes the handshake, and a following size byte is accepted normally.
- Illegal sizes: bytes 09, then 03 → err_size pulses twice and busy stays 0. Then size 00 → pkt_valid with pkt_data = {8'h00, 128'h0}.
- Timeout: send 04 74 FB, then idle for TIMEOUT_CYCLES (short value in bench, e.g. 16) → err_timeout pulse, state IDLE, no pkt_valid. A subsequent nominal packet assembles correctly with no stale bytes.
- Reset mid-packet: assert reset for 1 cycle during IDXS → all outputs 0 next cycle. The next nominal packet is correct.
